bram_row_streamer: RTL
======================

// Module: bram_row_streamer
// PURPOSE
// - Hardware successor to the bench-side result dump: after the SIMD core raises out_data_valid, control
//   starts a sweep of the result BRAM (port B) and this block streams every PE_COUNT-lane row out.
// - Generalised in lane count, width, depth and BRAM read latency; adds start address, row count,
//   address wrap, backpressure (valid/ready) and credit-based read issue.
// - Sits between the result BRAM port B and a host/DMA stream sink.
// PARAMETERS
// - PE_COUNT     4     lanes per BRAM row
// - DATA_WIDTH   32    bits per lane
// - BRAM_DEPTH   2048  rows in result BRAM; power of two, >= 2
// - ADDR_WIDTH   $clog2(BRAM_DEPTH)  row address width
// - RD_LATENCY   2     cycles from bram_en/bram_addr to valid bram_dout; 1..4
// - FIFO_DEPTH   4     output buffer rows; must be >= RD_LATENCY+1 (elaboration $error otherwise)
// PORTS
// - clk            in   1                      single clock; BRAM port B clock driven from it
// - rst            in   1                      synchronous, active-high reset
// - start          in   1                      1-cycle pulse: begin sweep
// - start_addr     in   ADDR_WIDTH             first row to read
// - row_count      in   ADDR_WIDTH+1           rows to read; 0..BRAM_DEPTH
// - busy           out  1                      sweep in progress
// - done           out  1                      1-cycle pulse: sweep complete
// - start_ignored  out  1                      1-cycle pulse: start seen while busy
// - bram_addr      out  ADDR_WIDTH             BRAM port B address
// - bram_en        out  1                      BRAM port B enable (read issue)
// - bram_dout      in   PE_COUNT*DATA_WIDTH    BRAM port B read data, lane 0 in LSBs
// - m_valid        out  1                      output row valid
// - m_ready        in   1                      sink ready
// - m_data         out  PE_COUNT*DATA_WIDTH    row data, lane 0 in LSBs
// - m_addr         out  ADDR_WIDTH             BRAM row of m_data
// - m_last         out  1                      final row of sweep
// BEHAVIOUR
// - Reset (rst=1 at posedge): all outputs 0, FSM IDLE, FIFO empty, in-flight reads discarded; reset
//   mid-sweep aborts with no done pulse. Same applies regardless of m_ready.
// - FSM IDLE -> ISSUE on start & row_count!=0: latch start_addr/row_count, busy=1 next cycle.
//   start & row_count==0: done pulses next cycle, busy stays 0, no BRAM reads.
// - ISSUE: bram_en=1 with bram_addr=next row only while (in_flight + fifo_count) < FIFO_DEPTH;
//   next row = (prev+1) mod BRAM_DEPTH (wraps BRAM_DEPTH-1 -> 0). After last issue -> DRAIN.
// - Read return: a RD_LATENCY-deep valid/addr/last tag pipe; bram_dout sampled when tag emerges and
//   pushed into FIFO with its address tag. Credit rule guarantees FIFO never overflows.
// - DRAIN -> IDLE when FIFO empty and m_last row accepted (m_valid&m_ready&m_last); done=1 that
//   next cycle, busy=0 same cycle as done.
// - Output: m_valid = FIFO non-empty; m_data/m_addr/m_last from FIFO head; stable while
//   m_valid & !m_ready. Rows delivered in issue order, exactly row_count rows, no duplicates.
// - Throughput: with m_ready held 1, one row per cycle; first m_valid RD_LATENCY+2 cycles after start.
// - start while busy: ignored, start_ignored pulses next cycle, sweep unaffected.
// - row_count > BRAM_DEPTH is clamped to BRAM_DEPTH.
// TESTING
// - BRAM model preloaded row r lanes = {4r+3,4r+2,4r+1,4r}; start_addr=0,row_count=75, m_ready=1
//   -> 75 rows in order, m_addr 0..74, m_last only on 74, done one cycle after, 1 row/cycle.
// - start_addr=2046,row_count=4 -> m_addr 2046,2047,0,1; lane data matches rows; m_last on row 1.
// - row_count=8, m_ready toggled 1/0 every cycle and held 0 for 10 cycles -> no loss/duplicate,
//   m_data stable during stalls, bram_en never asserted with 4 rows buffered/in flight.
// - row_count=0 -> done pulse 1 cycle after start, busy never 1, bram_en never 1, m_valid never 1.
// - start again at row 3 of a 10-row sweep -> start_ignored pulse, original 10 rows complete.
// - rst asserted mid-sweep (row 5 of 20) -> next cycle all outputs 0, no done; new start of 3 rows
//   at addr 100 -> exactly rows 100..102 delivered, no stale data from aborted sweep.
// - Repeat first scenario with RD_LATENCY=1 and 3, FIFO_DEPTH=RD_LATENCY+1 -> same row stream.

Source files
------------

// File: rtl/bram_row_streamer_if.sv
// Row stream from bram_row_streamer to a host/DMA sink: one BRAM row per
// valid/ready handshake, tagged with its source row address.
interface bram_row_streamer_if #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                           m_valid;
  logic                           m_ready;
  logic [PE_COUNT*DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH-1:0]          m_addr;
  logic                           m_last;

  modport master (output m_valid, m_data, m_addr, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_addr, m_last, output m_ready);
endinterface

// File: rtl/bram_row_streamer.sv
// Sweeps a contiguous (wrapping) range of result-BRAM rows through port B and
// streams each row out with backpressure, issuing reads only against free buffer credit.
//
// state | meaning
// IDLE  | waiting for start; no reads outstanding
// ISSUE | issuing row reads while buffer credit allows
// DRAIN | all reads issued; waiting for the last row to be accepted
module bram_row_streamer #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 2048,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          start_addr,
  input  logic [ADDR_WIDTH:0]            row_count,
  output logic                           busy,
  output logic                           done,
  output logic                           start_ignored,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  output logic                           bram_en,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_dout,
  bram_row_streamer_if.master            strm
);

  localparam int DW = PE_COUNT * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_fifo
    $error("bram_row_streamer: FIFO_DEPTH must be >= RD_LATENCY+1");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("bram_row_streamer: RD_LATENCY must be 1..4");
  end
  if (BRAM_DEPTH < 2 || (BRAM_DEPTH & (BRAM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bram_row_streamer: BRAM_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   rc_clamped;
  // occ counts rows issued but not yet accepted (in flight + buffered)
  logic [CW-1:0]         occ;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  logic [RD_LATENCY-1:0] tag_vld;
  logic [ADDR_WIDTH-1:0] tag_addr [RD_LATENCY];
  logic                  tag_last [RD_LATENCY];

  logic [DW-1:0]         mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic issue, start_go, start_zero, start_ign, finish;
  logic push, pop, fifo_ne, head_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rc_clamped = (row_count > (ADDR_WIDTH+1)'(BRAM_DEPTH)) ?
                      (ADDR_WIDTH+1)'(BRAM_DEPTH) : row_count;

  assign fifo_ne   = (fifo_cnt != '0);
  assign head_last = mem_last[rd_ptr];
  assign pop       = fifo_ne & strm.m_ready;
  assign push      = tag_vld[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    start_go   = 1'b0;
    start_zero = 1'b0;
    start_ign  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            start_zero = 1'b1;
          end else begin
            start_go  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        start_ign = start;
        issue     = (occ < CW'(FIFO_DEPTH));
        if (issue && issue_left == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        start_ign = start;
        if (pop && head_last) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr     <= '0;
      issue_left    <= '0;
      occ           <= '0;
      fifo_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tag_vld       <= '0;
      done          <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      done          <= start_zero | finish;
      start_ignored <= start_ign;
      if (start_go) begin
        next_addr  <= start_addr;
        issue_left <= rc_clamped;
      end else if (issue) begin
        next_addr  <= next_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      occ      <= occ + CW'(issue) - CW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      tag_vld[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  // Tag payload and buffer storage need no reset: qualified by tag_vld / fifo_cnt.
  always_ff @(posedge clk) begin
    tag_addr[0] <= next_addr;
    tag_last[0] <= (issue_left == (ADDR_WIDTH+1)'(1));
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_addr[i] <= tag_addr[i-1];
      tag_last[i] <= tag_last[i-1];
    end
    if (push) begin
      mem_data[wr_ptr] <= bram_dout;
      mem_addr[wr_ptr] <= tag_addr[RD_LATENCY-1];
      mem_last[wr_ptr] <= tag_last[RD_LATENCY-1];
    end
  end

  assign busy      = (state != IDLE);
  assign bram_en   = issue;
  assign bram_addr = next_addr;

  assign strm.m_valid = fifo_ne;
  assign strm.m_data  = fifo_ne ? mem_data[rd_ptr] : '0;
  assign strm.m_addr  = fifo_ne ? mem_addr[rd_ptr] : '0;
  assign strm.m_last  = fifo_ne & head_last;

endmodule
